i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx.sv | 187 ++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// I2C slave at address SLAVE_ADDR: stores written bytes in rx_data and returns tx_data on reads.
// rx_valid is high 1 cycle after the synchronized 8th SCL rise; bus timing is set by the master.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       nack_err
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic [3:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic [6:0]             r_tx_shift;
  logic                   r_rw;
  logic                   r_sda_oe;

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  assign sda = r_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync[0] <= scl_in;
      r_sda_sync[0] <= sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 7'd0;
      r_tx_shift <= 7'd0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
      nack_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      nack_err <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_sda_oe  <= 1'b0;
        busy      <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_sda_oe  <= 1'b0;
        busy      <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          IDLE: ;
          ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[5:0], w_sda};
              if (r_bit_cnt == 4'd7) begin
                r_rw <= w_sda;
                // r_shift still holds the 7 address bits; this rise carries R/W
                if (r_shift == SLAVE_ADDR) begin
                  r_state   <= ADDR_ACK;
                  busy      <= 1'b1;
                  r_bit_cnt <= 4'd8;
                end else begin
                  r_state   <= IDLE;
                  r_bit_cnt <= 4'd0;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_bit_cnt <= 4'd0;
                if (r_rw) begin
                  r_state    <= TX;
                  tx_load    <= 1'b1;
                  r_tx_shift <= tx_data[6:0];
                  r_sda_oe   <= ~tx_data[7];
                end else begin
                  r_state  <= RX;
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          RX: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[5:0], w_sda};
              if (r_bit_cnt == 4'd7) begin
                rx_data   <= {r_shift, w_sda};
                rx_valid  <= 1'b1;
                r_state   <= RX_ACK;
                r_bit_cnt <= 4'd8;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          RX_ACK: begin
            // first fall drives ACK, the fall ending the 9th pulse releases it
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_state   <= RX;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
              end
            end
          end
          TX: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= TX_ACK;
              end else begin
                r_sda_oe   <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            // a fall is only reached here after the master ACKed on the 9th rise
            if (w_scl_rise && w_sda) begin
              nack_err  <= 1'b1;
              r_state   <= IDLE;
              busy      <= 1'b0;
              r_bit_cnt <= 4'd0;
            end else if (w_scl_fall) begin
              r_state    <= TX;
              tx_load    <= 1'b1;
              r_tx_shift <= tx_data[6:0];
              r_sda_oe   <= ~tx_data[7];
              r_bit_cnt  <= 4'd0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged bus master with a pulled-up SDA line.
module tb_i2c_slave_rx;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, busy, nack_err;
  wire        sda_bus;

  int errors = 0;
  int checks = 0;
  int rxv_cyc = 0;
  int txl_cyc = 0;
  int nack_cyc = 0;
  int rxv0, txl0, nack0;
  logic       ack;
  logic [7:0] v;
  logic       s;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .scl_in  (scl),
    .sda     (sda_bus),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .busy    (busy),
    .nack_err(nack_err)
  );

  always @(negedge clk) begin
    if (rx_valid) rxv_cyc++;
    if (tx_load)  txl_cyc++;
    if (nack_err) nack_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quarter();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; quarter();
    scl = 1'b1;   quarter();
    m_low = 1'b1; quarter();
    scl = 1'b0;   quarter();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; quarter();
    scl = 1'b1;   quarter();
    m_low = 1'b0; quarter();
  endtask

  task automatic clock_bit(input logic b, output logic smp);
    m_low = ~b; quarter();
    scl = 1'b1; quarter();
    smp = sda_bus;
    quarter();
    scl = 1'b0; quarter();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], d);
    clock_bit(1'b1, a);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] val);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, d);
      val[i] = d;
    end
    clock_bit(~m_ack, d);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_load", {31'd0, tx_load}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_nack_err", {31'd0, nack_err}, 32'd0);
    check("reset_sda_released", {31'd0, sda_bus}, 32'd1);
    rst = 1'b1;
    quarter();

    // write 0x3C to address 0x50
    rxv0 = rxv_cyc;
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd0);
    check("wr_busy_after_match", {31'd0, busy}, 32'd1);
    write_byte(8'h3C, ack);
    check("wr_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    quarter();
    check("wr_rx_data", {24'd0, rx_data}, 32'h3C);
    check("wr_rx_valid_cycles", rxv_cyc - rxv0, 32'd1);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // wrong address 0x51 is NACKed and the following byte ignored
    rxv0 = rxv_cyc;
    i2c_start();
    write_byte(8'hA2, ack);
    check("badaddr_nack", {31'd0, ack}, 32'd1);
    check("badaddr_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h3C, ack);
    check("badaddr_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    quarter();
    check("badaddr_no_rx_valid", rxv_cyc - rxv0, 32'd0);
    check("badaddr_busy_end", {31'd0, busy}, 32'd0);

    // read 0x96 (ACK) then 0x5A (NACK)
    txl0 = txl_cyc; nack0 = nack_cyc;
    tx_data = 8'h96;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd0);
    tx_data = 8'h5A;
    read_byte(1'b1, v);
    check("rd_byte0", {24'd0, v}, 32'h96);
    read_byte(1'b0, v);
    check("rd_byte1", {24'd0, v}, 32'h5A);
    check("rd_busy_after_nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    quarter();
    check("rd_tx_load_cycles", txl_cyc - txl0, 32'd2);
    check("rd_nack_err_cycles", nack_cyc - nack0, 32'd1);

    // STOP after 4 data bits of a write
    rxv0 = rxv_cyc;
    i2c_start();
    write_byte(8'hA0, ack);
    check("part_addr_ack", {31'd0, ack}, 32'd0);
    clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b1, s);
    i2c_stop();
    quarter();
    check("part_no_rx_valid", rxv_cyc - rxv0, 32'd0);
    check("part_rx_data_kept", {24'd0, rx_data}, 32'h3C);
    check("part_busy", {31'd0, busy}, 32'd0);
    check("part_sda_released", {31'd0, sda_bus}, 32'd1);

    // repeated START after the address ACK, then a read
    i2c_start();
    write_byte(8'hA0, ack);
    check("rs_first_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    check("rs_busy_cleared", {31'd0, busy}, 32'd0);
    tx_data = 8'h81;
    txl0 = txl_cyc; nack0 = nack_cyc;
    write_byte(8'hA1, ack);
    check("rs_second_ack", {31'd0, ack}, 32'd0);
    check("rs_tx_load", txl_cyc - txl0, 32'd1);
    check("rs_busy_set", {31'd0, busy}, 32'd1);
    read_byte(1'b0, v);
    check("rs_read_byte", {24'd0, v}, 32'h81);
    i2c_stop();
    quarter();
    check("rs_nack_err", nack_cyc - nack0, 32'd1);

    // asynchronous reset while the address ACK is driven low
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(logic'((8'hA0 >> i) & 8'h01), s);
    m_low = 1'b0; quarter();
    scl = 1'b1;   quarter();
    check("arst_ack_driven", {31'd0, sda_bus}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("arst_sda_released", {31'd0, sda_bus}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_rx_data", {24'd0, rx_data}, 32'h00);
    check("arst_outputs", {29'd0, rx_valid, tx_load, nack_err}, 32'd0);
    scl = 1'b0; quarter();
    rst = 1'b1; quarter();
    write_byte(8'hA0, ack);
    check("post_rst_ignored", {31'd0, ack}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    check("post_rst_fresh_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    quarter();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
